// File: rtl/code_patch_loader_if.sv
// Bus bundle between the host sequencer, the patch loader and the patch core.
// The loader takes the master modport; the host/core side takes the slave modport.
interface code_patch_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 12,
    parameter int NUM_REGS   = 21
);
    localparam int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int IDX_W               = $clog2(NUM_REGS);

    // host sequencer side
    logic                           start_i;
    logic [IDX_W-1:0]               num_entries_i;
    logic                           entry_valid_i;
    logic [ADDR_WIDTH-1:0]          entry_addr_i;
    logic [DATA_WIDTH-1:0]          entry_data_i;
    logic                           entry_ready_o;
    // patch core side
    logic                           ctl_pat_we_o;
    logic [IDX_W-1:0]               ctl_pat_idx_o;
    logic [SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_o;
    logic                           ctl_pat_ack_i;
    logic                           cfg_pat_gen_o;
    // status
    logic                           busy_o;
    logic                           done_o;
    logic                           err_o;

    modport master (
        input  start_i, num_entries_i, entry_valid_i, entry_addr_i, entry_data_i, ctl_pat_ack_i,
        output entry_ready_o, ctl_pat_we_o, ctl_pat_idx_o, ctl_pat_data_o, cfg_pat_gen_o,
               busy_o, done_o, err_o
    );

    modport slave (
        output start_i, num_entries_i, entry_valid_i, entry_addr_i, entry_data_i, ctl_pat_ack_i,
        input  entry_ready_o, ctl_pat_we_o, ctl_pat_idx_o, ctl_pat_data_o, cfg_pat_gen_o,
               busy_o, done_o, err_o
    );
endinterface

// File: rtl/code_patch_loader.sv
// Code patch loader: takes (address, data) patch entries from the host,
// writes them as sub-register pairs into the patch core, writes the entry
// count into the last sub-register, then pulses the regenerate strobe.
// Every core write waits for an ack; a missing ack aborts the load with err.
module code_patch_loader #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 12,
    parameter int NUM_REGS    = 21,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    code_patch_loader_if.master bus
);
    localparam int SUB_W       = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int IDX_W       = $clog2(NUM_REGS);
    localparam int MAX_ENTRIES = (NUM_REGS - 1) / 2;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_CTRL = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] IDX_MAXN = IDX_W'(MAX_ENTRIES);
    // Abort fires on the edge that closes the ACK_TIMEOUT-th unacked cycle.
    localparam logic [7:0]       TMO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WR_ADDR = 3'd2,
        WR_DATA = 3'd3,
        WR_CTRL = 3'd4,
        GEN     = 3'd5
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    count_r;
    logic [IDX_W-1:0]    k_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [7:0]          tmo_r;

    logic                ready_r;
    logic                we_r;
    logic [IDX_W-1:0]    idx_r;
    logic [SUB_W-1:0]    wdata_r;
    logic                gen_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic [IDX_W-1:0]    k_next_s;
    logic                acked_s;
    logic                tmo_hit_s;

    assign k_next_s  = k_r + IDX_ONE;
    assign acked_s   = we_r & bus.ctl_pat_ack_i;
    assign tmo_hit_s = (tmo_r == TMO_LAST);

    // Load sequencer: state, captured entry, and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            count_r <= IDX_ZERO;
            k_r     <= IDX_ZERO;
            addr_r  <= '0;
            data_r  <= '0;
            tmo_r   <= 8'd0;
            ready_r <= 1'b0;
            we_r    <= 1'b0;
            idx_r   <= IDX_ZERO;
            wdata_r <= '0;
            gen_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            gen_r  <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start_i) begin
                        if (bus.num_entries_i > IDX_MAXN) begin
                            err_r <= 1'b1;
                        end else if (bus.num_entries_i == IDX_ZERO) begin
                            count_r <= IDX_ZERO;
                            state_r <= WR_CTRL;
                            busy_r  <= 1'b1;
                            we_r    <= 1'b1;
                            idx_r   <= IDX_CTRL;
                            wdata_r <= '0;
                            tmo_r   <= 8'd0;
                        end else begin
                            count_r <= bus.num_entries_i;
                            k_r     <= IDX_ZERO;
                            state_r <= FETCH;
                            busy_r  <= 1'b1;
                            ready_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (bus.entry_valid_i && ready_r) begin
                        addr_r  <= bus.entry_addr_i;
                        data_r  <= bus.entry_data_i;
                        ready_r <= 1'b0;
                        state_r <= WR_ADDR;
                        we_r    <= 1'b1;
                        idx_r   <= k_r << 1;
                        wdata_r <= SUB_W'(bus.entry_addr_i);
                        tmo_r   <= 8'd0;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                WR_ADDR, WR_DATA, WR_CTRL: begin
                    if (acked_s) begin
                        tmo_r <= 8'd0;
                        if (state_r == WR_ADDR) begin
                            // back-to-back: we stays high, idx/data move on
                            state_r <= WR_DATA;
                            idx_r   <= (k_r << 1) | IDX_ONE;
                            wdata_r <= SUB_W'(data_r);
                        end else if (state_r == WR_DATA) begin
                            k_r <= k_next_s;
                            if (k_next_s == count_r) begin
                                state_r <= WR_CTRL;
                                idx_r   <= IDX_CTRL;
                                wdata_r <= SUB_W'(count_r);
                            end else begin
                                state_r <= FETCH;
                                we_r    <= 1'b0;
                                ready_r <= 1'b1;
                            end
                        end else begin
                            state_r <= GEN;
                            we_r    <= 1'b0;
                            gen_r   <= 1'b1;
                            done_r  <= 1'b1;
                        end
                    end else if (tmo_hit_s) begin
                        // core never answered: abandon the load, no regenerate
                        state_r <= IDLE;
                        we_r    <= 1'b0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b0;
                        err_r   <= 1'b1;
                        tmo_r   <= 8'd0;
                    end else begin
                        tmo_r <= tmo_r + 8'd1;
                    end
                end
                GEN: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.entry_ready_o  = ready_r;
    assign bus.ctl_pat_we_o   = we_r;
    assign bus.ctl_pat_idx_o  = idx_r;
    assign bus.ctl_pat_data_o = wdata_r;
    assign bus.cfg_pat_gen_o  = gen_r;
    assign bus.busy_o         = busy_r;
    assign bus.done_o         = done_r;
    assign bus.err_o          = err_r;
endmodule

// File: tb/tb_code_patch_loader.sv
// Self-checking bench for code_patch_loader: a table of load scenarios with
// hand-computed timing, plus a reset-during-write sequence.
module tb_code_patch_loader;
    localparam int AW   = 32;
    localparam int DW   = 12;
    localparam int NR   = 21;
    localparam int TMO  = 4;
    localparam int IW   = 5;
    localparam int SW   = 32;

    logic clk;
    logic rst_ni;

    code_patch_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) bus ();

    code_patch_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .ACK_TIMEOUT(TMO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int num;
        int delay;     // unacked cycles before the core acks each write
        int block;     // sub-register index that is never acked (-1: none)
        int restart;   // cycle at which start is pulsed again while busy (0: none)
        int exp_gen;   // cycle of cfg_pat_gen (0: never)
        int exp_err;   // cycle of err (0: never)
        int exp_nwr;   // acked writes
        int exp_busy;  // last cycle busy is high (0: never)
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] ent_addr [10];
    logic [DW-1:0] ent_data [10];

    int ack_delay = 0;
    int block_idx = -1;
    int wcnt      = 0;
    logic prev_we = 1'b0;
    logic [IW-1:0] prev_idx = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle to the sampling point and play the core's ack side.
    task automatic step();
        @(negedge clk);
        #1;
        if (bus.ctl_pat_we_o) begin
            if (!prev_we || bus.ctl_pat_idx_o != prev_idx) wcnt = 0;
            else wcnt = wcnt + 1;
        end else begin
            wcnt = 0;
        end
        prev_we  = bus.ctl_pat_we_o;
        prev_idx = bus.ctl_pat_idx_o;
        bus.ctl_pat_ack_i = bus.ctl_pat_we_o && (int'(bus.ctl_pat_idx_o) != block_idx) && (wcnt >= ack_delay);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int ptr = 0;
        logic prev_acc = 1'b0;
        int gen_cyc = 0, gen_cnt = 0, err_cyc = 0, err_cnt = 0, busy_last = 0;
        int done_bad = 0, stable_bad = 0, we_at_err = 0;
        logic p_we = 1'b0;
        logic [IW-1:0] p_idx = '0;
        logic [SW-1:0] p_data = '0;
        int log_idx[$];
        longint log_dat[$];
        int exp_idx[$];
        longint exp_dat[$];
        int mism = 0;

        ack_delay = v.delay;
        block_idx = v.block;
        bus.entry_valid_i = 1'b1;
        bus.entry_addr_i  = ent_addr[0];
        bus.entry_data_i  = ent_data[0];
        bus.num_entries_i = IW'(v.num);
        bus.start_i       = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (prev_acc) ptr++;
            if (ptr < 10) begin
                bus.entry_addr_i = ent_addr[ptr];
                bus.entry_data_i = ent_data[ptr];
            end
            bus.start_i = (c == v.restart);
            prev_acc = bus.entry_ready_o && bus.entry_valid_i;
            if (bus.cfg_pat_gen_o) begin gen_cnt++; if (gen_cyc == 0) gen_cyc = c; end
            if (bus.err_o) begin err_cnt++; if (err_cyc == 0) err_cyc = c; we_at_err = int'(bus.ctl_pat_we_o); end
            if (bus.busy_o) busy_last = c;
            if (bus.done_o != bus.cfg_pat_gen_o) done_bad++;
            if (bus.ctl_pat_we_o && p_we && bus.ctl_pat_idx_o == p_idx && bus.ctl_pat_data_o != p_data) stable_bad++;
            p_we = bus.ctl_pat_we_o; p_idx = bus.ctl_pat_idx_o; p_data = bus.ctl_pat_data_o;
            if (bus.ctl_pat_we_o && bus.ctl_pat_ack_i) begin
                log_idx.push_back(int'(bus.ctl_pat_idx_o));
                log_dat.push_back(longint'(bus.ctl_pat_data_o));
            end
        end
        bus.start_i = 1'b0;

        if (v.num <= 10) begin
            for (int k = 0; k < v.num; k++) begin
                exp_idx.push_back(2 * k);     exp_dat.push_back(longint'(ent_addr[k]));
                exp_idx.push_back(2 * k + 1); exp_dat.push_back(longint'(ent_data[k]));
            end
            exp_idx.push_back(NR - 1); exp_dat.push_back(longint'(v.num));
        end
        for (int i = 0; i < log_idx.size() && i < exp_idx.size(); i++) begin
            if (log_idx[i] != exp_idx[i] || log_dat[i] != exp_dat[i]) begin
                mism++;
                $display("  %s write %0d: idx %0d data 0x%0h, wanted idx %0d data 0x%0h",
                         tag, i, log_idx[i], log_dat[i], exp_idx[i], exp_dat[i]);
            end
        end

        chk({tag, ".gen_cycle"}, gen_cyc, v.exp_gen);
        chk({tag, ".gen_count"}, gen_cnt, (v.exp_gen != 0) ? 1 : 0);
        chk({tag, ".done_eq_gen"}, done_bad, 0);
        chk({tag, ".err_cycle"}, err_cyc, v.exp_err);
        chk({tag, ".err_count"}, err_cnt, (v.exp_err != 0) ? 1 : 0);
        chk({tag, ".nwrites"}, log_idx.size(), v.exp_nwr);
        chk({tag, ".write_content"}, mism, 0);
        chk({tag, ".hold_stable"}, stable_bad, 0);
        chk({tag, ".busy_last"}, busy_last, v.exp_busy);
        if (err_cyc != 0) chk({tag, ".we_at_err"}, we_at_err, 0);
    endtask

    vec_t vecs [12];

    initial begin
        int found;
        vec_t again;

        ent_addr[0] = 32'h0000_1000; ent_data[0] = 12'h0AB;
        ent_addr[1] = 32'h0000_2004; ent_data[1] = 12'h123;
        for (int i = 2; i < 10; i++) begin
            ent_addr[i] = 32'h8000_0000 | (32'(i) << 8) | 32'h10;
            ent_data[i] = 12'(i * 7 + 1);
        end

        //            num delay block restart gen err nwr busy
        vecs[0]  = '{  2,   0,   -1,    0,     8,  0,  5,   8};
        vecs[1]  = '{  0,   0,   -1,    0,     2,  0,  1,   2};
        vecs[2]  = '{ 11,   0,   -1,    0,     0,  1,  0,   0};
        vecs[3]  = '{  1,   3,   -1,    0,    14,  0,  3,  14};
        vecs[4]  = '{  1,   0,    1,    0,     0,  7,  1,   6};
        vecs[5]  = '{  3,   0,   -1,    0,    11,  0,  7,  11};
        vecs[6]  = '{ 10,   0,   -1,    0,    32,  0, 21,  32};
        vecs[7]  = '{  1,   1,   -1,    0,     8,  0,  3,   8};
        vecs[8]  = '{ 15,   0,   -1,    0,     0,  1,  0,   0};
        vecs[9]  = '{  0,   4,   -1,    0,     0,  5,  0,   4};
        vecs[10] = '{  0,   3,   -1,    0,     5,  0,  1,   5};
        vecs[11] = '{  1,   0,   -1,    3,     5,  0,  3,   5};

        rst_ni = 1'b0;
        bus.start_i = 1'b0; bus.num_entries_i = '0; bus.entry_valid_i = 1'b0;
        bus.entry_addr_i = '0; bus.entry_data_i = '0; bus.ctl_pat_ack_i = 1'b0;
        step(); step();
        chk("reset_outputs",
            longint'({bus.entry_ready_o, bus.ctl_pat_we_o, bus.ctl_pat_idx_o, bus.ctl_pat_data_o,
                      bus.cfg_pat_gen_o, bus.busy_o, bus.done_o, bus.err_o}), 0);
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of WR_DATA, with a start pulse while busy first.
        ack_delay = 0; block_idx = 1;
        bus.entry_valid_i = 1'b1; bus.entry_addr_i = ent_addr[0]; bus.entry_data_i = ent_data[0];
        bus.num_entries_i = IW'(2); bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step();
            if (bus.ctl_pat_we_o && bus.ctl_pat_idx_o == IW'(1)) found = 1;
        end
        chk("rst.reached_wr_data", found, 1);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        chk("rst.busy_start_ignored", longint'({bus.ctl_pat_we_o, bus.ctl_pat_idx_o, bus.ctl_pat_data_o}),
            longint'({1'b1, 5'd1, 32'h0AB}));
        rst_ni = 1'b0;
        #1;
        chk("rst.async_outputs",
            longint'({bus.entry_ready_o, bus.ctl_pat_we_o, bus.ctl_pat_idx_o, bus.ctl_pat_data_o,
                      bus.cfg_pat_gen_o, bus.busy_o, bus.done_o, bus.err_o}), 0);
        step();
        rst_ni = 1'b1;
        found = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.ctl_pat_we_o || bus.cfg_pat_gen_o || bus.busy_o || bus.err_o) found++;
        end
        chk("rst.quiet_after", found, 0);
        again = vecs[0];
        run_vec(again, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
